// File: rtl/lo_sweep_sequencer_pkg.sv
// lo_sweep_sequencer_pkg: shared types and constants for the LO sweep sequencer.
// Holds the FSM state encoding, divider limits and divider helper functions.
package lo_sweep_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DWELL  = 2'd2
  } state_e;

  localparam logic [2:0] DIV_MIN = 3'd1;
  localparam logic [2:0] DIV_MAX = 3'd7;

  localparam int SETTLE_CYC_DEF = 8;

  // The divider treats 0 and 1 identically, so 0 is folded onto 1.
  function automatic logic [2:0] norm_div(input logic [2:0] d);
    return (d == 3'd0) ? DIV_MIN : d;
  endfunction

  // One step toward the end setting; never wraps through 0/7.
  function automatic logic [2:0] step_div(input logic [2:0] d,
                                          input logic       up);
    if (up) return (d == DIV_MAX) ? d : d + 3'd1;
    else    return (d == DIV_MIN) ? d : d - 3'd1;
  endfunction

endpackage

// File: rtl/lo_step_timer.sv
// lo_step_timer: loadable down-counter with a terminal indication.
// Ports: clk, rst_n, load_i/load_val_i (preset), en_i (count), zero_o (count is 0).
module lo_step_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Loaded with N-1 on entry, so zero marks the Nth (last) cycle.
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lo_sweep_sequencer.sv
// lo_sweep_sequencer: steps the internal LO divider through a range with settle/dwell
// timing, mutes during retune, and yields to external-LO requests.
// Ports: clk, rst_n; start/stop pulses; continuous, start_div, end_div, dwell
// (latched at start); ext_req; outputs ext_lo_en, int_lo_settings, mute, busy,
// step_done, sweep_done (all registered).
module lo_sweep_sequencer
  import lo_sweep_sequencer_pkg::*;
#(
  parameter int DWELL_W    = 16,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int SETTLE_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [2:0]         start_div,
  input  logic [2:0]         end_div,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               ext_req,
  output logic               ext_lo_en,
  output logic [2:0]         int_lo_settings,
  output logic               mute,
  output logic               busy,
  output logic               step_done,
  output logic               sweep_done
);

  localparam logic [SETTLE_W-1:0] ST_LOAD =
    SETTLE_W'(SETTLE_CYC - 1);

  state_e state_q, state_d;

  logic               ext_q;
  logic               ext_en_q, ext_en_d;
  logic [2:0]         set_q, set_d;
  logic               mute_q, mute_d;
  logic               busy_q, busy_d;
  logic               step_q, step_d;
  logic               sweep_q, sweep_d;
  logic               cont_q, cont_d;
  logic               up_q, up_d;
  logic [2:0]         first_q, first_d;
  logic [2:0]         last_q, last_d;
  logic [DWELL_W-1:0] dwm1_q, dwm1_d;

  logic st_load, st_en, st_zero;
  logic dw_load, dw_en, dw_zero;

  logic [2:0] sd_n, ed_n;
  logic       abort;

  assign sd_n  = norm_div(start_div);
  assign ed_n  = norm_div(end_div);
  // Only a rising ext_req aborts; a held request keeps the block idle.
  assign abort = stop | (ext_req & ~ext_q);

  lo_step_timer #(.W(SETTLE_W)) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (st_load),
    .load_val_i (ST_LOAD),
    .en_i       (st_en),
    .zero_o     (st_zero)
  );

  lo_step_timer #(.W(DWELL_W)) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (dw_load),
    .load_val_i (dwm1_q),
    .en_i       (dw_en),
    .zero_o     (dw_zero)
  );

  always_comb begin
    state_d  = state_q;
    ext_en_d = ext_en_q;
    set_d    = set_q;
    mute_d   = mute_q;
    busy_d   = busy_q;
    step_d   = 1'b0;
    sweep_d  = 1'b0;
    cont_d   = cont_q;
    up_d     = up_q;
    first_d  = first_q;
    last_d   = last_q;
    dwm1_d   = dwm1_q;
    st_load  = 1'b0;
    st_en    = 1'b0;
    dw_load  = 1'b0;
    dw_en    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ext_en_d = ext_req;
        if (start && !ext_req && !stop) begin
          cont_d  = continuous;
          first_d = sd_n;
          last_d  = ed_n;
          up_d    = (ed_n >= sd_n);
          dwm1_d  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          set_d   = sd_n;
          mute_d  = 1'b1;
          busy_d  = 1'b1;
          st_load = 1'b1;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          ext_en_d = ext_req;
          mute_d   = 1'b0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else if (st_zero) begin
          mute_d  = 1'b0;
          dw_load = 1'b1;
          state_d = S_DWELL;
        end else begin
          st_en = 1'b1;
        end
      end

      S_DWELL: begin
        if (abort) begin
          ext_en_d = ext_req;
          mute_d   = 1'b0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else if (dw_zero) begin
          step_d = 1'b1;
          if (set_q != last_q) begin
            set_d   = step_div(set_q, up_q);
            mute_d  = 1'b1;
            st_load = 1'b1;
            state_d = S_SETTLE;
          end else begin
            sweep_d = 1'b1;
            if (cont_q) begin
              set_d   = first_q;
              mute_d  = 1'b1;
              st_load = 1'b1;
              state_d = S_SETTLE;
            end else begin
              ext_en_d = ext_req;
              busy_d   = 1'b0;
              state_d  = S_IDLE;
            end
          end
        end else begin
          dw_en = 1'b1;
        end
      end

      default: begin
        mute_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ext_q    <= 1'b0;
      ext_en_q <= 1'b0;
      set_q    <= DIV_MIN;
      mute_q   <= 1'b0;
      busy_q   <= 1'b0;
      step_q   <= 1'b0;
      sweep_q  <= 1'b0;
      cont_q   <= 1'b0;
      up_q     <= 1'b0;
      first_q  <= DIV_MIN;
      last_q   <= DIV_MIN;
      dwm1_q   <= '0;
    end else begin
      state_q  <= state_d;
      ext_q    <= ext_req;
      ext_en_q <= ext_en_d;
      set_q    <= set_d;
      mute_q   <= mute_d;
      busy_q   <= busy_d;
      step_q   <= step_d;
      sweep_q  <= sweep_d;
      cont_q   <= cont_d;
      up_q     <= up_d;
      first_q  <= first_d;
      last_q   <= last_d;
      dwm1_q   <= dwm1_d;
    end
  end

  assign ext_lo_en       = ext_en_q;
  assign int_lo_settings = set_q;
  assign mute            = mute_q;
  assign busy            = busy_q;
  assign step_done       = step_q;
  assign sweep_done      = sweep_q;

endmodule

// File: tb/tb_lo_sweep_sequencer.sv
// tb_lo_sweep_sequencer: scoreboard bench for lo_sweep_sequencer.
// Expected done pulses are queued at start; a monitor pops them as pulses appear.
module tb_lo_sweep_sequencer;

  localparam int SC = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [2:0]  start_div = 3'd0;
  logic [2:0]  end_div = 3'd0;
  logic [15:0] dwell = 16'd0;
  logic        ext_req = 1'b0;
  logic        ext_lo_en;
  logic [2:0]  int_lo_settings;
  logic        mute;
  logic        busy;
  logic        step_done;
  logic        sweep_done;

  lo_sweep_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .stop            (stop),
    .continuous      (continuous),
    .start_div       (start_div),
    .end_div         (end_div),
    .dwell           (dwell),
    .ext_req         (ext_req),
    .ext_lo_en       (ext_lo_en),
    .int_lo_settings (int_lo_settings),
    .mute            (mute),
    .busy            (busy),
    .step_done       (step_done),
    .sweep_done      (sweep_done)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int cyc;
    bit sweep;
    int set;
  } exp_t;

  exp_t expq[$];

  function automatic void check(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)",
               nm, act, want, cyc);
    end
  endfunction

  function automatic int nrm(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Reference: each step lasts SC+dwell cycles; the done pulse of step k
  // lands (k+1)*len cycles after the start edge, with the next setting.
  function automatic void push_exp(input int sd, input int ed,
                                   input int dw, input bit cont,
                                   input int nsw, input int maxev,
                                   input int t0);
    int s, e, d, dir, n, len, k;
    exp_t x;
    s   = nrm(sd);
    e   = nrm(ed);
    d   = nrm(dw);
    dir = (e >= s) ? 1 : -1;
    n   = (e - s) * dir + 1;
    len = SC + d;
    k   = 0;
    for (int w = 0; w < nsw; w++) begin
      for (int i = 0; i < n; i++) begin
        if (k >= maxev) return;
        x.cyc   = t0 + (w * n + i + 1) * len;
        x.sweep = (i == n - 1);
        x.set   = (i < n - 1) ? s + dir * (i + 1) : (cont ? s : e);
        expq.push_back(x);
        k++;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && (step_done || sweep_done)) begin
      if (expq.size() == 0) begin
        check("unexpected_pulse", 32'(1), 32'(0));
      end else begin
        exp_t x;
        x = expq.pop_front();
        check("done_cycle", 32'(cyc), 32'(x.cyc));
        check("step_done", 32'(step_done), 32'(1));
        check("sweep_done", 32'(sweep_done), 32'(x.sweep));
        check("next_setting", 32'(int_lo_settings), 32'(x.set));
      end
    end
  end

  task automatic pulse_start(input int sd, input int ed, input int dw,
                             input bit cont, output int t0);
    start_div  = sd[2:0];
    end_div    = ed[2:0];
    dwell      = dw[15:0];
    continuous = cont;
    start      = 1'b1;
    t0         = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ext_lo_en"}, 32'(ext_lo_en), 32'(0));
    check({tag, "_setting"}, 32'(int_lo_settings), 32'(1));
    check({tag, "_mute"}, 32'(mute), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_step_done"}, 32'(step_done), 32'(0));
    check({tag, "_sweep_done"}, 32'(sweep_done), 32'(0));
  endtask

  task automatic run_sweep(input int sd, input int ed, input int dw,
                           input bit poke);
    int s, e, d, dir, n, len, total, t0, xs;
    s     = nrm(sd);
    e     = nrm(ed);
    d     = nrm(dw);
    dir   = (e >= s) ? 1 : -1;
    n     = (e - s) * dir + 1;
    len   = SC + d;
    total = n * len;
    push_exp(sd, ed, dw, 1'b0, 1, 100, cyc + 1);
    pulse_start(sd, ed, dw, 1'b0, t0);
    for (int j = 0; j <= total; j++) begin
      xs = (j < total) ? s + dir * (j / len) : e;
      check("trace_setting", 32'(int_lo_settings), 32'(xs));
      check("trace_mute", 32'(mute),
            32'(j < total && (j % len) < SC));
      check("trace_busy", 32'(busy), 32'(j < total));
      if (poke && j == 5) begin
        start_div = 3'd7;
        end_div   = 3'd1;
        dwell     = 16'd9;
        start     = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    check("missed_events", 32'(expq.size()), 32'(0));
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("after_reset");

    run_sweep(2, 4, 3, 1'b0);
    run_sweep(0, 5, 2, 1'b0);
    run_sweep(6, 2, 1, 1'b0);
    run_sweep(3, 3, 0, 1'b0);
    run_sweep(7, 7, 2, 1'b0);
    run_sweep(2, 5, 2, 1'b1);

    for (int i = 0; i < 8; i++)
      run_sweep(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 4)), (i % 3) == 0);

    // Continuous 3..5, stop sampled on the final dwell cycle of step 7.
    push_exp(3, 5, 3, 1'b1, 2, 100, cyc + 1);
    pulse_start(3, 5, 3, 1'b1, t0);
    repeat (76) @(negedge clk);
    check("cont_wrap_setting", 32'(int_lo_settings), 32'(3));
    check("cont_busy", 32'(busy), 32'(1));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    continuous = 1'b0;
    check("stop_busy", 32'(busy), 32'(0));
    check("stop_mute", 32'(mute), 32'(0));
    check("stop_setting", 32'(int_lo_settings), 32'(3));
    check("stop_step_done", 32'(step_done), 32'(0));
    repeat (20) @(negedge clk);
    check("stop_idle_setting", 32'(int_lo_settings), 32'(3));
    check("cont_missed", 32'(expq.size()), 32'(0));

    // External request rising during the settle of step 2.
    push_exp(2, 6, 2, 1'b0, 1, 1, cyc + 1);
    pulse_start(2, 6, 2, 1'b0, t0);
    repeat (13) @(negedge clk);
    check("pre_ext_mute", 32'(mute), 32'(1));
    ext_req = 1'b1;
    @(negedge clk);
    check("ext_busy", 32'(busy), 32'(0));
    check("ext_lo_en", 32'(ext_lo_en), 32'(1));
    check("ext_mute", 32'(mute), 32'(0));
    check("ext_setting", 32'(int_lo_settings), 32'(3));
    start_div = 3'd1;
    end_div   = 3'd2;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ext_start_ignored", 32'(busy), 32'(0));
    check("ext_lo_en_held", 32'(ext_lo_en), 32'(1));
    ext_req = 1'b0;
    @(negedge clk);
    check("ext_lo_en_fall", 32'(ext_lo_en), 32'(0));
    check("ext_idle_busy", 32'(busy), 32'(0));
    check("ext_missed", 32'(expq.size()), 32'(0));

    // Asynchronous reset in the middle of a dwell.
    pulse_start(1, 4, 4, 1'b0, t0);
    repeat (10) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_missed", 32'(expq.size()), 32'(0));
    run_sweep(5, 3, 1, 1'b0);

    // Start and stop together: stop wins.
    start_div = 3'd2;
    end_div   = 3'd6;
    start     = 1'b1;
    stop      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", 32'(busy), 32'(0));
    check("startstop_setting", 32'(int_lo_settings), 32'(3));
    check("startstop_mute", 32'(mute), 32'(0));
    repeat (5) @(negedge clk);
    check("final_missed", 32'(expq.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
